// File: rtl/tape_cache_bram_if.sv
// Bus between the cassette loader and its tape-image cache: the ioctl download
// write port plus the cs-gated read port of the parser.
interface tape_cache_bram_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int INIT_AW    = 25
);
  logic                  bram_download;
  logic                  bram_wr;
  logic [INIT_AW-1:0]    bram_init_address;
  logic [DATA_WIDTH-1:0] bram_din;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] dout;
  logic                  cs;

  modport master (
    output bram_download, bram_wr, bram_init_address, bram_din, addr, cs,
    input  dout
  );

  modport slave (
    input  bram_download, bram_wr, bram_init_address, bram_din, addr, cs,
    output dout
  );
endinterface

// File: rtl/tape_cache_bram.sv
// Byte-wide tape-image cache: sequentially filled by the ioctl download stream,
// read back through a single registered, cs-gated, read-first port.
module tape_cache_bram #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int INIT_AW    = 25
) (
  input  logic               clk,
  input  logic               reset,
  tape_cache_bram_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Zero content both in simulation and as the synthesis init image.
  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1] = '{default: '0};
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  addr_in_range;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;

  // ioctl addresses beyond the cache depth are dropped rather than wrapped.
  generate
    if (INIT_AW > ADDR_WIDTH) begin : g_range_check
      assign addr_in_range = (bus.bram_init_address[INIT_AW-1:ADDR_WIDTH] == '0);
    end else begin : g_no_range_check
      assign addr_in_range = 1'b1;
    end
  endgenerate

  assign wr_addr = bus.bram_init_address[ADDR_WIDTH-1:0];
  assign wr_en   = bus.bram_download & bus.bram_wr & addr_in_range;

  // Write and read share one process so reset gates both without the array
  // itself being reset; the read samples the pre-write contents (read-first).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_addr] <= bus.bram_din;
      end
      if (bus.cs) begin
        dout_q <= mem_q[bus.addr];
      end
    end
  end

  assign bus.dout = dout_q;
endmodule

// File: tb/tb_tape_cache_bram.sv
// Self-checking bench for tape_cache_bram: directed scenarios plus randomized
// traffic checked against a byte-array reference of the cache.
module tb_tape_cache_bram;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] model [0:65535];
  logic [7:0] img   [0:31];
  logic [7:0] exp_dout;

  tape_cache_bram_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .INIT_AW(25)) bus ();

  tape_cache_bram #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .INIT_AW(25)) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock edge, updating the reference cache with what that edge should do.
  task automatic step();
    if (rst) begin
      exp_dout = 8'h00;
    end else begin
      if (bus.cs) exp_dout = model[bus.addr];
      if (bus.bram_download && bus.bram_wr && (bus.bram_init_address >> 16) == 0)
        model[bus.bram_init_address[15:0]] = bus.bram_din;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.bram_download = 1'b0;
    bus.bram_wr       = 1'b0;
    bus.cs            = 1'b0;
  endtask

  task automatic dl_write(input logic [24:0] a, input logic [7:0] d);
    bus.bram_download     = 1'b1;
    bus.bram_wr           = 1'b1;
    bus.bram_init_address = a;
    bus.bram_din          = d;
    step();
    idle();
  endtask

  task automatic rd(input logic [15:0] a);
    bus.cs   = 1'b1;
    bus.addr = a;
    step();
    bus.cs   = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.dout !== 8'h00) begin
      failures++;
      $display("FAIL reset_state dout=%h expected=%h", bus.dout, 8'h00);
    end
    rst = 1'b0;
    step();
    dl_write(25'h00040, 8'hA5);
    rd(16'h0040);
    checks++;
    if (bus.dout !== 8'hA5) begin
      failures++;
      $display("FAIL reset_preload dout=%h expected=%h", bus.dout, 8'hA5);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.dout !== 8'h00) begin
      failures++;
      $display("FAIL reset_async dout=%h expected=%h", bus.dout, 8'h00);
    end
    // Traffic presented during reset must have no effect.
    bus.bram_download = 1'b1; bus.bram_wr = 1'b1;
    bus.bram_init_address = 25'h00020; bus.bram_din = 8'hEE;
    bus.cs = 1'b1; bus.addr = 16'h0040;
    step();
    idle();
    checks++;
    if (bus.dout !== 8'h00) begin
      failures++;
      $display("FAIL reset_hold dout=%h expected=%h", bus.dout, 8'h00);
    end
    rst = 1'b0;
    step();
    rd(16'h0020);
    checks++;
    if (bus.dout !== 8'h00) begin
      failures++;
      $display("FAIL reset_write_ignored dout=%h expected=%h", bus.dout, 8'h00);
    end
  endtask

  task automatic test_download_sweep();
    img[0] = 8'h16; img[1] = 8'h16; img[2] = 8'h24; img[3] = 8'h00;
    for (int i = 4; i < 32; i++) img[i] = 8'($urandom);
    bus.bram_download = 1'b1;
    bus.bram_wr       = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.bram_init_address = 25'(i);
      bus.bram_din          = img[i];
      step();
    end
    idle();
    bus.cs = 1'b1;
    for (int a = 6; a <= 14; a++) begin
      bus.addr = 16'(a);
      step();
      checks++;
      if (bus.dout !== img[a]) begin
        failures++;
        $display("FAIL sweep addr=%0d dout=%h expected=%h", a, bus.dout, img[a]);
      end
    end
    bus.cs = 1'b0;
  endtask

  task automatic test_wr_without_download();
    dl_write(25'h00010, 8'h5A);
    bus.bram_download = 1'b0; bus.bram_wr = 1'b1;
    bus.bram_init_address = 25'h00010; bus.bram_din = 8'hFF;
    step();
    idle();
    rd(16'h0010);
    checks++;
    if (bus.dout !== 8'h5A) begin
      failures++;
      $display("FAIL wr_no_download dout=%h expected=%h", bus.dout, 8'h5A);
    end
  endtask

  task automatic test_high_address();
    dl_write(25'h10005, 8'h3C);
    rd(16'h0005);
    checks++;
    if (bus.dout !== img[5]) begin
      failures++;
      $display("FAIL high_addr_discard dout=%h expected=%h", bus.dout, img[5]);
    end
  endtask

  task automatic test_cs_hold();
    rd(16'h0007);
    bus.addr = 16'h0008;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.dout !== img[7]) begin
        failures++;
        $display("FAIL cs_hold cyc=%0d dout=%h expected=%h", i, bus.dout, img[7]);
      end
    end
    rd(16'h0008);
    checks++;
    if (bus.dout !== img[8]) begin
      failures++;
      $display("FAIL cs_resume dout=%h expected=%h", bus.dout, img[8]);
    end
  endtask

  task automatic test_read_first();
    dl_write(25'h00100, 8'h11);
    bus.bram_download = 1'b1; bus.bram_wr = 1'b1;
    bus.bram_init_address = 25'h00100; bus.bram_din = 8'h77;
    bus.cs = 1'b1; bus.addr = 16'h0100;
    step();
    bus.bram_download = 1'b0; bus.bram_wr = 1'b0;
    checks++;
    if (bus.dout !== 8'h11) begin
      failures++;
      $display("FAIL read_first_old dout=%h expected=%h", bus.dout, 8'h11);
    end
    step();
    idle();
    checks++;
    if (bus.dout !== 8'h77) begin
      failures++;
      $display("FAIL read_first_new dout=%h expected=%h", bus.dout, 8'h77);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      bus.bram_download     = 1'($urandom_range(0, 3) != 0);
      bus.bram_wr           = 1'($urandom_range(0, 1));
      bus.bram_init_address = 25'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) bus.bram_init_address[16 + $urandom_range(0, 8)] = 1'b1;
      bus.bram_din          = 8'($urandom);
      bus.cs                = 1'($urandom_range(0, 1));
      bus.addr              = 16'($urandom_range(0, 63));
      step();
      checks++;
      if (bus.dout !== exp_dout) begin
        failures++;
        errs++;
        if (errs <= 10)
          $display("FAIL random cyc=%0d dout=%h expected=%h", i, bus.dout, exp_dout);
      end
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) model[i] = 8'h00;
    exp_dout = 8'h00;
    bus.bram_init_address = '0;
    bus.bram_din          = '0;
    bus.addr              = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_download_sweep();
    test_wr_without_download();
    test_high_address();
    test_cs_hold();
    test_read_first();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
